// File: rtl/systolic_feeder_4x4.sv
// Operand sequencer for a 4x4 systolic array: latches an A/B tile pair, clears the
// array, streams the diagonally skewed wavefront, waits out the drain, then pulses done.

module feeder_lane #(
    parameter int BIT_WIDTH = 16,
    parameter int LANE      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     feed,
    input  logic [2:0]               t,
    input  logic [3:0][BIT_WIDTH-1:0] ops,
    output logic [BIT_WIDTH-1:0]     operand
);
    // k = t - LANE; a negative difference wraps high and fails the k < 4 test
    logic [3:0] k;
    assign k = {1'b0, t} - 4'(LANE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            operand <= '0;
        else
            operand <= (feed && k < 4'd4) ? ops[k[1:0]] : '0;
    end
endmodule

module systolic_feeder_4x4 #(
    parameter int BIT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [16*BIT_WIDTH-1:0]   a_tile,
    input  logic [16*BIT_WIDTH-1:0]   b_tile,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic                      array_rst_n,
    output logic [BIT_WIDTH-1:0]      west_in0,
    output logic [BIT_WIDTH-1:0]      west_in1,
    output logic [BIT_WIDTH-1:0]      west_in2,
    output logic [BIT_WIDTH-1:0]      west_in3,
    output logic [BIT_WIDTH-1:0]      north_in0,
    output logic [BIT_WIDTH-1:0]      north_in1,
    output logic [BIT_WIDTH-1:0]      north_in2,
    output logic [BIT_WIDTH-1:0]      north_in3
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_t;

    state_t                    state, state_n;
    logic [2:0]                t, t_n;
    logic [DW-1:0]             dcnt, dcnt_n;
    logic [15:0][BIT_WIDTH-1:0] a_q, b_q;
    logic [3:0][BIT_WIDTH-1:0]  west, north;
    logic                      feed_n;

    always_comb begin
        state_n = state;
        t_n     = t;
        dcnt_n  = dcnt;
        case (state)
            IDLE:  if (start) state_n = CLR;
            CLR: begin
                state_n = FEED;
                t_n     = '0;
            end
            FEED: begin
                if (t == 3'd6) begin
                    state_n = DRAIN;
                    t_n     = '0;
                    dcnt_n  = '0;
                end else begin
                    t_n = t + 3'd1;
                end
            end
            DRAIN: begin
                if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
                    state_n = DONE;
                    dcnt_n  = '0;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            t           <= '0;
            dcnt        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            array_rst_n <= 1'b0;
        end else begin
            state       <= state_n;
            t           <= t_n;
            dcnt        <= dcnt_n;
            if (state == IDLE && start) begin
                a_q <= a_tile;
                b_q <= b_tile;
            end
            ready       <= (state_n == IDLE);
            busy        <= (state_n == CLR) || (state_n == FEED) || (state_n == DRAIN);
            done        <= (state_n == DONE);
            array_rst_n <= (state_n != CLR);
        end
    end

    assign feed_n = (state_n == FEED);

    // Lane g feeds row g of A on the west edge and column g of B on the north edge
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [3:0][BIT_WIDTH-1:0] w_ops, n_ops;
        for (genvar k = 0; k < 4; k++) begin : g_op
            assign w_ops[k] = a_q[4*g+k];
            assign n_ops[k] = b_q[4*k+g];
        end
        feeder_lane #(.BIT_WIDTH(BIT_WIDTH), .LANE(g)) u_west (
            .clk(clk), .rst(rst), .feed(feed_n), .t(t_n), .ops(w_ops), .operand(west[g])
        );
        feeder_lane #(.BIT_WIDTH(BIT_WIDTH), .LANE(g)) u_north (
            .clk(clk), .rst(rst), .feed(feed_n), .t(t_n), .ops(n_ops), .operand(north[g])
        );
    end

    assign west_in0  = west[0];
    assign west_in1  = west[1];
    assign west_in2  = west[2];
    assign west_in3  = west[3];
    assign north_in0 = north[0];
    assign north_in1 = north[1];
    assign north_in2 = north[2];
    assign north_in3 = north[3];
endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Scoreboard bench for systolic_feeder_4x4: per-cycle expected outputs are queued at
// start, and a behavioural Q8.8 systolic array checks the resulting C tile at done.

module tb_systolic_feeder_4x4;
    localparam int BW = 16;
    localparam int DC = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [16*BW-1:0] a_tile = '0, b_tile = '0;
    logic ready, busy, done, array_rst_n;
    logic [BW-1:0] west_in0, west_in1, west_in2, west_in3;
    logic [BW-1:0] north_in0, north_in1, north_in2, north_in3;
    logic [3:0][BW-1:0] west_v, north_v;

    systolic_feeder_4x4 #(.BIT_WIDTH(BW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .start(start), .a_tile(a_tile), .b_tile(b_tile),
        .ready(ready), .busy(busy), .done(done), .array_rst_n(array_rst_n),
        .west_in0(west_in0), .west_in1(west_in1), .west_in2(west_in2), .west_in3(west_in3),
        .north_in0(north_in0), .north_in1(north_in1), .north_in2(north_in2), .north_in3(north_in3)
    );

    always #5 clk = ~clk;

    assign west_v  = {west_in3, west_in2, west_in1, west_in0};
    assign north_v = {north_in3, north_in2, north_in1, north_in0};

    typedef struct packed {
        logic ready, busy, done, arst;
        logic [3:0][BW-1:0] west, north;
    } obs_t;

    obs_t         sb_q[$];
    logic [255:0] res_q[$];
    int errors = 0;
    int checks = 0;
    logic [15:0] ma[4][4], mb[4][4];

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Behavioural Q8.8 array: operands hop one PE per cycle, acc += (w*n)>>8
    logic [15:0] wr[4][4], nr[4][4], acc[4][4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                automatic logic [15:0] w, n;
                automatic logic [31:0] p;
                if (j == 0) w = west_v[i]; else w = wr[i][j-1];
                if (i == 0) n = north_v[j]; else n = nr[i-1][j];
                p = 32'(w) * 32'(n);
                if (!array_rst_n) begin
                    wr[i][j]  <= '0;
                    nr[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    wr[i][j]  <= w;
                    nr[i][j]  <= n;
                    acc[i][j] <= acc[i][j] + p[23:8];
                end
            end
        end
    end

    function automatic obs_t exp_at(input int c);
        obs_t e;
        int t;
        e = '0;
        e.arst = 1'b1;
        if (c == 0) e.ready = 1'b1;
        else if (c == 1) begin
            e.busy = 1'b1;
            e.arst = 1'b0;
        end else if (c <= 8) begin
            e.busy = 1'b1;
            t = c - 2;
            for (int i = 0; i < 4; i++) begin
                if (t - i >= 0 && t - i <= 3) begin
                    e.west[i]  = ma[i][t-i];
                    e.north[i] = mb[t-i][i];
                end
            end
        end else if (c <= 8 + DC) e.busy = 1'b1;
        else e.done = 1'b1;
        return e;
    endfunction

    task automatic load_tile();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_tile[(4*i+k)*BW +: BW] = ma[i][k];
                b_tile[(4*i+k)*BW +: BW] = mb[i][k];
            end
    endtask

    // Cycle S (idle with start) plus the 14 cycles through DONE, and the C tile
    task automatic push_tile();
        logic [3:0][3:0][15:0] c;
        logic [31:0] p;
        for (int x = 0; x <= 9 + DC; x++) sb_q.push_back(exp_at(x));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < 4; k++) begin
                    p = 32'(ma[i][k]) * 32'(mb[k][j]);
                    c[i][j] = c[i][j] + p[23:8];
                end
            end
        res_q.push_back(256'(c));
    endtask

    task automatic run_start();
        @(posedge clk); #1;
        load_tile();
        start = 1'b1;
        push_tile();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        obs_t o;
        logic [3:0][3:0][15:0] mc;
        o.ready = ready; o.busy = busy; o.done = done; o.arst = array_rst_n;
        o.west = west_v; o.north = north_v;
        if (rst) begin
            chk("reset_ctl", 256'({ready, busy, done, array_rst_n}), 256'(4'b1000));
            chk("reset_ops", 256'({west_v, north_v}), 256'(0));
        end else if (sb_q.size() > 0) begin
            chk("seq", 256'(o), 256'(sb_q.pop_front()));
        end else begin
            chk("idle", 256'({ready, busy, done, west_v, north_v}), 256'({3'b100, 128'b0}));
        end
        if (!rst && done) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) mc[i][j] = acc[i][j];
            if (res_q.size() > 0) chk("result", 256'(mc), res_q.pop_front());
            else chk("spurious_done", 256'(done), 256'(0));
        end
    end

    initial begin
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_held", 256'(array_rst_n), 256'(0));
        @(negedge clk);
        chk("arst_rise", 256'(array_rst_n), 256'(1));
        wait_cycles(2);

        // identity A (1.0 in Q8.8) times integer B
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (i == k) ? 16'h0100 : 16'h0000;
                mb[i][k] = 16'(4*i + k);
            end
        run_start();
        wait_cycles(15);

        // skew waveform, plus an ignored start with other tiles at S+5
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'(16*i + k);
                mb[i][k] = 16'(32 + 16*i + k);
            end
        run_start();
        wait_cycles(3);
        @(negedge clk);
        chk("skew_west", 256'(west_v), 256'({16'h0000, 16'h0020, 16'h0011, 16'h0002}));
        chk("skew_north", 256'(north_v), 256'({16'h0000, 16'h0022, 16'h0031, 16'h0040}));
        @(posedge clk); #1;
        a_tile = ~a_tile;
        b_tile = ~b_tile;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cycles(14);

        // back-to-back: start held from the DONE cycle into the following cycle
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'($urandom_range(0, 16'hffff));
                mb[i][k] = 16'($urandom_range(0, 16'hffff));
            end
        run_start();
        wait_cycles(13);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'($urandom_range(0, 16'h0fff));
                mb[i][k] = 16'($urandom_range(0, 16'h0fff));
            end
        load_tile();
        start = 1'b1;
        wait_cycles(1);
        push_tile();
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(15);

        // reset during FEED at t=3, then a fresh tile
        run_start();
        wait_cycles(4);
        rst = 1'b1;
        sb_q.delete();
        res_q.delete();
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3);
        run_start();
        wait_cycles(15);

        // all-ones in Q8.8: every element 4.0
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 16'h0100;
                mb[i][k] = 16'h0100;
            end
        run_start();
        wait_cycles(15);

        chk("sb_empty", 256'(sb_q.size()), 256'(0));
        chk("res_empty", 256'(res_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_feeder_4x4.md
# systolic_feeder_4x4

Upstream operand sequencer for the 4x4 systolic array. It accepts one 4x4 A tile and one 4x4 B tile in a single cycle and clears the array's accumulators. It then drives the array's `west_in0..3` and `north_in0..3` ports with the diagonally skewed operand wavefront, and waits a fixed drain time. Finally it pulses `done`, at which point the array's registered `row0..row3` hold the C = A x B tile.

## Interface
- `BIT_WIDTH`, 16: operand width; matches the array's `BIT_WIDTH`.
- `DRAIN_CYCLES`, 5: cycles between the last feed cycle and `done`; covers PE propagation plus the array's output register.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a tile; accepted only when `ready`=1.
- `a_tile`  in  16*BIT_WIDTH  A[i][k] at bits `[(4*i+k)*BIT_WIDTH +: BIT_WIDTH]`; sampled on accepted `start`.
- `b_tile`  in  16*BIT_WIDTH  B[k][j] at bits `[(4*k+j)*BIT_WIDTH +: BIT_WIDTH]`; sampled on accepted `start`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in CLR, FEED and DRAIN.
- `done`  out  1  one-cycle pulse; the array result is valid.
- `array_rst_n`  out  1  active-low accumulator clear to the array's `rst_n`.
- `west_in0..3`  out  BIT_WIDTH each  row operands to the array's `west_in0..3`.
- `north_in0..3`  out  BIT_WIDTH each  column operands to the array's `north_in0..3`.

## Operation
- FSM states: IDLE, CLR, FEED, DRAIN, DONE.
- **IDLE**
  - `ready`=1. All operand outputs are 0.
  - On `start`=1: latch `a_tile`/`b_tile` into internal tile registers, go to CLR.
- **CLR**
  - One cycle with `array_rst_n`=0. Operand outputs are 0.
  - Go to FEED with the feed counter t=0.
- **FEED**
  - 7 cycles, t=0..6; t is a 3-bit counter.
  - `west_in_i` = A[i][t-i] when 0 <= t-i <= 3, else 0.
  - `north_in_j` = B[t-j][j] when 0 <= t-j <= 3, else 0.
  - After t=6, go to DRAIN.
- **DRAIN**
  - Operand outputs are 0. The drain counter counts `DRAIN_CYCLES` cycles, then the FSM goes to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
  - The array's accumulators are left untouched so `row0..3` remain readable until the next CLR.
- **Control rules**
  - `start` outside IDLE is ignored. The tile registers do not change.
  - `start` in the same cycle as DONE is ignored. The earliest accepted start is the cycle after `done`.
- **Outputs**
  - All operand and control outputs are registered.
  - Operand values are passed through bit-exact. The block does no arithmetic on operand values, so `FRAC_WIDTH` is irrelevant here.
- **Reset**
  - Reset, including mid-FEED or mid-DRAIN, forces IDLE immediately.
  - Tile registers, counters and all operand outputs are cleared to 0.
  - `array_rst_n`=0 while `rst`=1, so the array is cleared too.
  - No `done` is issued for an aborted tile.

## Timing
- **Reset values**
  - `ready`=1, `busy`=0, `done`=0, `array_rst_n`=0.
  - All `west_in*`/`north_in*` = 0.
  - `array_rst_n` rises on the first clock edge after `rst` deasserts.
- **Cycle numbering:** cycle S is the cycle with `start`=1 sampled in IDLE.
- **S+1 (CLR)**
  - `ready`=0, `busy`=1, `array_rst_n`=0.
- **S+2..S+8 (FEED, t=0..6)**
  - Skewed operands as defined above.
  - Example: at t=0 only `west_in0`=A[0][0] and `north_in0`=B[0][0] are nonzero.
  - At t=6 only `west_in3`=A[3][3] and `north_in3`=B[3][3] are nonzero.
- **S+9..S+8+DRAIN_CYCLES (DRAIN):** operand outputs are 0.
- **S+9+DRAIN_CYCLES (DONE)**
  - `done`=1, `busy`=0. This is S+14 at the default.
- **Array-side timing**
  - A[i][k] reaches PE(i,j) at t=i+j+k, with one register per hop.
  - The last MAC is at PE(3,3), t=9, i.e. S+11.
  - That value is in `row3` after the PE result register and the array output register, at S+13.
  - `DRAIN_CYCLES`=5 therefore gives one cycle of margin.
- **Throughput:** one tile per 9+`DRAIN_CYCLES`+1 cycles, 15 at the default.

## Test plan
- **Identity:** A=I, B[k][j]=4k+j (integers in low bits), start pulse.
  - `done` at S+14.
  - Array `row0..3` equals B, packed row-major with column 0 in the MSBs.
- **Skew waveform:** A[i][k]=0x10*i+k, B[k][j]=0x20+0x10*k+j.
  - At S+4 (t=2): `west_in0`=0x0002, `west_in1`=0x0011, `west_in2`=0x0020, `west_in3`=0.
  - At S+4: `north_in0`=0x0040, `north_in1`=0x0031, `north_in2`=0x0022, `north_in3`=0.
- **Start while busy:** second start with different tiles at S+5.
  - It is ignored: FEED values and the result are unchanged, with exactly one `done`.
- **Back-to-back:** two tiles, second start in the cycle after the first `done`.
  - `array_rst_n` is low for exactly one cycle before each FEED.
  - The second result contains no residue of the first.
- **Reset mid-FEED:** assert `rst` at t=3 for 2 cycles.
  - Outputs go to 0 and `array_rst_n`=0 immediately; `ready`=1 after release; no `done`.
  - A new tile then completes normally.
- **A=B=all 0x0100 (1.0 in Q8.8):** every array result element is 0x0400.
